// File: rtl/arb_req_fifo.sv
// arb_req_fifo: first-word-fall-through request FIFO in front of the arbiter.
// Storage is a two-port RAM (port A write-only, port B registered read). The
// port-B output register doubles as the FIFO output stage, so capacity is
// DEPTH + 1 words. Optional macro ARB_FIFO_LEVEL_EN adds a registered
// occupancy output (levelOut).
module arb_req_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clockIn,
    input  logic                  resetIn_n,
    input  logic                  inValidIn,
    input  logic [DATA_WIDTH-1:0] inDataIn,
    output logic                  inReadyOut,
    output logic                  outValidOut,
    output logic [DATA_WIDTH-1:0] outDataOut,
    input  logic                  outReadyIn
`ifdef ARB_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] levelOut
`endif
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = Depth[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic push;
    logic pop;
    logic fetch;

    // Handshake decode; ready depends only on registered state.
    always_comb begin
        inReadyOut = (ram_count_q != DepthCnt);
        push       = inValidIn & inReadyOut;
        pop        = out_valid_q & outReadyIn;
        // Refill the output stage whenever it is empty or being drained.
        fetch      = (ram_count_q != '0) & (~out_valid_q | outReadyIn);
    end

    // Next-state for pointers, RAM occupancy and output-stage valid.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_count_d = ram_count_q;
        out_valid_d = out_valid_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !fetch) begin
            ram_count_d = ram_count_q + 1'b1;
        end else if (!push && fetch) begin
            ram_count_d = ram_count_q - 1'b1;
        end
        if (fetch) begin
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    // Control state; reset discards contents immediately.
    always_ff @(posedge clockIn or negedge resetIn_n) begin
        if (!resetIn_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_count_q <= ram_count_d;
            out_valid_q <= out_valid_d;
        end
    end

    // RAM port A: write-only.
    always_ff @(posedge clockIn) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= inDataIn;
        end
    end

    // RAM port B: registered read, enabled only on fetch so the head holds.
    always_ff @(posedge clockIn) begin
        if (fetch) begin
            rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign outValidOut = out_valid_q;
    assign outDataOut  = rd_data_q;

`ifdef ARB_FIFO_LEVEL_EN
    logic [ADDR_WIDTH+1:0] level_q, level_d;

    // Occupancy = RAM entries plus the output stage, tracked on the same edge.
    always_comb begin
        level_d = {1'b0, ram_count_d} + {{(ADDR_WIDTH + 1){1'b0}}, out_valid_d};
    end

    // Occupancy register.
    always_ff @(posedge clockIn or negedge resetIn_n) begin
        if (!resetIn_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign levelOut = level_q;
`endif

endmodule

// File: tb/tb_arb_req_fifo.sv
// Directed and randomised bench for arb_req_fifo (ADDR_WIDTH=2: DEPTH=4, capacity 5).
module tb_arb_req_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
`ifdef ARB_FIFO_LEVEL_EN
    logic [3:0] level;
`endif

    int n_cmp = 0;
    int n_err = 0;

    arb_req_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(2)
    ) dut (
        .clockIn    (clk),
        .resetIn_n  (rst_n),
        .inValidIn  (in_valid),
        .inDataIn   (in_data),
        .inReadyOut (in_ready),
        .outValidOut(out_valid),
        .outDataOut (out_data),
        .outReadyIn (out_ready)
`ifdef ARB_FIFO_LEVEL_EN
        ,
        .levelOut   (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sb[$];
    logic [7:0] exp_b;
    logic [7:0] held;
    int         idx;
    int         nout;
    int         bubbles;
    int         first_c;
    logic       push_now;
    logic       pop_now;
    logic       stall;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
`ifdef ARB_FIFO_LEVEL_EN
        check("rst_level", level, 0);
`endif
        rst_n = 1'b1;
        step();
        check("idle_out_valid", out_valid, 0);

        // Single push, 2-edge latency then drained
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        step();
        in_valid = 1'b0;
        check("single_not_yet", out_valid, 0);
        step();
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 8'hA5);
        step();
        check("single_drained", out_valid, 0);

        // Fill with downstream stalled; 0x06 must be held off
        out_ready = 1'b0;
        idx = 1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = idx[7:0];
            push_now = in_ready;
            step();
            if (push_now) idx++;
        end
        check("fill_accepted", idx - 1, 5);
        check("fill_in_ready", in_ready, 0);
        check("fill_head_valid", out_valid, 1);
        check("fill_head_data", out_data, 8'h01);
`ifdef ARB_FIFO_LEVEL_EN
        check("fill_level", level, 5);
`endif
        in_valid = 1'b0;

        // One-cycle pop from full; ready rises only after the edge
        out_ready = 1'b1;
        check("pop_ready_not_comb", in_ready, 0);
        step();
        out_ready = 1'b0;
        check("pop_head_valid", out_valid, 1);
        check("pop_head_data", out_data, 8'h02);
        check("pop_in_ready", in_ready, 1);
`ifdef ARB_FIFO_LEVEL_EN
        check("pop_level", level, 4);
`endif
        step();
        check("stall_hold_data", out_data, 8'h02);

        // Drain remaining 0x03..0x05
        out_ready = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            step();
            exp_b = k[7:0];
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, exp_b);
        end
        step();
        check("drain_empty", out_valid, 0);

        // Continuous stream 0x00..0xFF, push and pop every cycle
        exp_b   = 8'h00;
        nout    = 0;
        bubbles = 0;
        first_c = -1;
        for (int c = 0; c < 262; c++) begin
            in_valid = (c < 256);
            in_data  = c[7:0];
            if (c < 256) check("stream_in_ready", in_ready, 1);
            step();
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                check("stream_data", out_data, exp_b);
                exp_b++;
                nout++;
            end else if (first_c >= 0 && nout < 256) begin
                bubbles++;
            end
`ifdef ARB_FIFO_LEVEL_EN
            check("stream_level_le2", level <= 2, 1);
`endif
        end
        check("stream_latency", first_c, 1);
        check("stream_count", nout, 256);
        check("stream_bubbles", bubbles, 0);

        // Random traffic against a scoreboard
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = 8'($urandom_range(0, 255));
            out_ready = $urandom_range(0, 1) == 1;
            push_now  = in_valid && in_ready;
            pop_now   = out_valid && out_ready;
            stall     = out_valid && !out_ready;
            held      = out_data;
            if (pop_now) begin
                if (sb.size() == 0) check("rand_underflow", out_valid, 0);
                else check("rand_data", out_data, sb.pop_front());
            end
            if (push_now) sb.push_back(in_data);
            step();
            if (stall) begin
                check("rand_stall_valid", out_valid, 1);
                check("rand_stall_data", out_data, held);
            end
`ifdef ARB_FIFO_LEVEL_EN
            check("rand_level", level, sb.size());
`endif
        end

        // Drain what the scoreboard still expects
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                if (sb.size() == 0) check("drain2_extra", out_valid, 0);
                else check("drain2_data", out_data, sb.pop_front());
            end
            step();
        end
        check("drain2_left", sb.size(), 0);
        check("drain2_empty", out_valid, 0);

        // Asynchronous reset with words in flight
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_data  = 8'h70 + 8'(c);
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 1);
`ifdef ARB_FIFO_LEVEL_EN
        check("async_rst_level", level, 0);
`endif
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("post_rst_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
